// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the
// load-use hazard, taken-branch redirect, multi-cycle data-memory waits and
// multi-cycle mult/div operations into per-stage pipeline-register write
// enables and flushes. Carries a small FSM for the multi-cycle waits, a
// watchdog that halts the pipe on a hung wait, and a saturating count of
// cycles in which the PC was not written.
//
// Parameters:
//   CNT_W     width of the stall_cycles counter
//   MAX_WAIT  consecutive cycles allowed in MEM_WAIT/MD_WAIT (1..65535)
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load_use_hazard       ID reads the rt of a load now in EX
//   branch_taken          EX resolved a taken branch/jump
//   dmem_req, dmem_ready  MEM access issued / completing this cycle
//   md_start, md_done     EX holds a mult/div / its result is valid
//   pc_write .. memwb_flush  per-stage write enables and flushes
//   stall_cycles          saturating count of cycles with pc_write=0
//   timeout_err           sticky watchdog error
//   ctrl_state            RUN=0, MEM_WAIT=1, MD_WAIT=2, HALT=3
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             timeout_err,
    output logic [1:0]       ctrl_state
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StMdWait  = 2'd2,
        StHalt    = 2'd3
    } state_e;

    // Last allowed value of the wait counter before the watchdog fires.
    localparam logic [15:0] WaitLimit = 16'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic mem_stall;
    logic md_stall;

    assign mem_stall = dmem_req & ~dmem_ready;
    assign md_stall  = md_start & ~md_done;

    // Rule selection and next state. The rule flags are resolved into
    // outputs further down so every state shares one priority chain.
    logic rule_p1, rule_p2, rule_p3, rule_p4;
    logic md_hold;
    logic halted;

    always_comb begin
        rule_p1    = 1'b0;
        rule_p2    = 1'b0;
        rule_p3    = 1'b0;
        rule_p4    = 1'b0;
        md_hold    = 1'b0;
        halted     = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StRun: begin
                rule_p1 = mem_stall;
                rule_p2 = md_stall;
                rule_p3 = branch_taken;
                rule_p4 = load_use_hazard;
                if (mem_stall) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end else if (md_stall) begin
                    state_d    = StMdWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    rule_p1 = 1'b1;
                    if (wait_cnt_q >= WaitLimit) begin
                        state_d   = StHalt;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    rule_p2 = md_stall;
                    rule_p3 = branch_taken;
                    rule_p4 = load_use_hazard;
                    if (md_stall) begin
                        state_d    = StMdWait;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StMdWait: begin
                if (!md_done) begin
                    // A mem-stall here only freezes outputs; the MD wait owns the state.
                    md_hold = 1'b1;
                    rule_p1 = mem_stall;
                    if (wait_cnt_q >= WaitLimit) begin
                        state_d   = StHalt;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    rule_p1 = mem_stall;
                    rule_p3 = branch_taken;
                    rule_p4 = load_use_hazard;
                    if (mem_stall) begin
                        state_d    = StMemWait;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    // Output resolution.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (!reset_n || halted) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else begin
            if (md_hold) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
            end
            if (rule_p1) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                memwb_flush = 1'b1;
            end else if (!md_hold) begin
                if (rule_p2) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                end else if (rule_p3) begin
                    // The load-use dependent is squashed, so the hazard is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (rule_p4) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign timeout_err  = timeout_q;
    assign ctrl_state   = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench. dut_a (default parameters) runs a table of per-cycle
// vectors and a reset-in-MD_WAIT sequence; dut_b (CNT_W=3, MAX_WAIT=4) shares
// the inputs but has its own reset and covers the watchdog and counter
// saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    // Output bundle order: {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f}
    localparam logic [7:0] O_DEF  = 8'b1101_0100;
    localparam logic [7:0] O_FRZ  = 8'b0000_0001;
    localparam logic [7:0] O_MD   = 8'b0000_0110;
    localparam logic [7:0] O_MDMS = 8'b0000_0011;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_LU   = 8'b0001_1100;
    localparam logic [7:0] O_OFF  = 8'b0000_0000;

    // Input bundle order: {lu, br, req, rdy, mds, mdd}
    typedef struct {
        logic [5:0]  in;
        logic [7:0]  out;
        logic [1:0]  st;
        int unsigned cnt;
    } vec_t;

    localparam int NV = 27;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    logic lu, br, req, rdy, mds, mdd;

    logic a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_wbf, a_to;
    logic [31:0] a_cnt;
    logic [1:0]  a_st;
    logic b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_wbf, b_to;
    logic [2:0]  b_cnt;
    logic [1:0]  b_st;
    logic [7:0]  a_out, b_out;

    int total = 0;
    int bad   = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign a_out = {a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_wbf};
    assign b_out = {b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_wbf};

    pipeline_stall_controller dut_a (
        .clk             (clk),
        .reset_n         (rst_a_n),
        .load_use_hazard (lu),
        .branch_taken    (br),
        .dmem_req        (req),
        .dmem_ready      (rdy),
        .md_start        (mds),
        .md_done         (mdd),
        .pc_write        (a_pc),
        .ifid_write      (a_ifw),
        .ifid_flush      (a_iff),
        .idex_write      (a_idw),
        .idex_flush      (a_idf),
        .exmem_write     (a_exw),
        .exmem_flush     (a_exf),
        .memwb_flush     (a_wbf),
        .stall_cycles    (a_cnt),
        .timeout_err     (a_to),
        .ctrl_state      (a_st)
    );

    pipeline_stall_controller #(
        .CNT_W    (3),
        .MAX_WAIT (4)
    ) dut_b (
        .clk             (clk),
        .reset_n         (rst_b_n),
        .load_use_hazard (lu),
        .branch_taken    (br),
        .dmem_req        (req),
        .dmem_ready      (rdy),
        .md_start        (mds),
        .md_done         (mdd),
        .pc_write        (b_pc),
        .ifid_write      (b_ifw),
        .ifid_flush      (b_iff),
        .idex_write      (b_idw),
        .idex_flush      (b_idf),
        .exmem_write     (b_exw),
        .exmem_flush     (b_exf),
        .memwb_flush     (b_wbf),
        .stall_cycles    (b_cnt),
        .timeout_err     (b_to),
        .ctrl_state      (b_st)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] v);
        {lu, br, req, rdy, mds, mdd} = v;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // lu br req rdy mds mdd
        vecs[0]  = '{6'b000000, O_DEF,  2'd0, 0};   // idle
        vecs[1]  = '{6'b100000, O_LU,   2'd0, 0};   // load-use bubble
        vecs[2]  = '{6'b000000, O_DEF,  2'd0, 1};
        vecs[3]  = '{6'b110000, O_BR,   2'd0, 1};   // branch beats load-use
        vecs[4]  = '{6'b000000, O_DEF,  2'd0, 1};
        vecs[5]  = '{6'b000011, O_DEF,  2'd0, 1};   // md start+done same cycle
        vecs[6]  = '{6'b101100, O_LU,   2'd0, 1};   // ready access, no mem-stall
        vecs[7]  = '{6'b001000, O_FRZ,  2'd0, 2};   // mem-stall from RUN
        vecs[8]  = '{6'b001000, O_FRZ,  2'd1, 3};
        vecs[9]  = '{6'b001000, O_FRZ,  2'd1, 4};
        vecs[10] = '{6'b001100, O_DEF,  2'd1, 5};   // release
        vecs[11] = '{6'b000000, O_DEF,  2'd0, 5};
        vecs[12] = '{6'b000010, O_MD,   2'd0, 5};   // md cycle 1
        vecs[13] = '{6'b001010, O_MDMS, 2'd2, 6};   // md cycle 2 + mem-stall
        vecs[14] = '{6'b000010, O_MD,   2'd2, 7};
        vecs[15] = '{6'b000010, O_MD,   2'd2, 8};
        vecs[16] = '{6'b000010, O_MD,   2'd2, 9};
        vecs[17] = '{6'b000011, O_DEF,  2'd2, 10};  // md_done
        vecs[18] = '{6'b000000, O_DEF,  2'd0, 10};
        vecs[19] = '{6'b001000, O_FRZ,  2'd0, 10};
        vecs[20] = '{6'b011110, O_MD,   2'd1, 11};  // mem release, md stall wins over branch
        vecs[21] = '{6'b110011, O_BR,   2'd2, 12};  // md release with branch+hazard
        vecs[22] = '{6'b000000, O_DEF,  2'd0, 12};
        vecs[23] = '{6'b000010, O_MD,   2'd0, 12};
        vecs[24] = '{6'b001011, O_FRZ,  2'd2, 13};  // md release with mem-stall
        vecs[25] = '{6'b101100, O_LU,   2'd1, 14};  // mem release into load-use
        vecs[26] = '{6'b000000, O_DEF,  2'd0, 15};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        set_in(6'b000000);
        repeat (2) next_cycle();

        // Reset state.
        #3;
        chk("rst_a_out", 32'(a_out), 32'(O_OFF));
        chk("rst_a_state", 32'(a_st), 32'd0);
        chk("rst_a_cnt", a_cnt, 32'd0);
        chk("rst_a_timeout", 32'(a_to), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'(O_OFF));
        next_cycle();
        rst_a_n = 1'b1;

        // Table: one record per cycle, outputs checked mid-cycle.
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].in);
            #3;
            chk($sformatf("vec%0d_out", i), 32'(a_out), 32'(vecs[i].out));
            chk($sformatf("vec%0d_state", i), 32'(a_st), 32'(vecs[i].st));
            chk($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].cnt);
            next_cycle();
        end
        chk("table_timeout", 32'(a_to), 32'd0);

        // Reset asserted mid MD_WAIT acts without a clock edge.
        set_in(6'b000010);
        repeat (3) next_cycle();
        #3;
        chk("mdrst_state_before", 32'(a_st), 32'd2);
        chk("mdrst_cnt_before", a_cnt, 32'd18);
        chk("mdrst_out_before", 32'(a_out), 32'(O_MD));
        rst_a_n = 1'b0;
        #2;
        chk("mdrst_out", 32'(a_out), 32'(O_OFF));
        chk("mdrst_state", 32'(a_st), 32'd0);
        chk("mdrst_cnt", a_cnt, 32'd0);
        chk("mdrst_timeout", 32'(a_to), 32'd0);
        next_cycle();
        rst_a_n = 1'b1;
        set_in(6'b000000);
        #3;
        chk("mdrst_release_out", 32'(a_out), 32'(O_DEF));
        chk("mdrst_release_state", 32'(a_st), 32'd0);
        next_cycle();

        // Watchdog on dut_b: MAX_WAIT=4, dmem_ready held low.
        rst_b_n = 1'b1;
        #3;
        chk("wd_idle_out", 32'(b_out), 32'(O_DEF));
        next_cycle();
        set_in(6'b001000);
        #3;
        chk("wd_run_out", 32'(b_out), 32'(O_FRZ));
        chk("wd_run_state", 32'(b_st), 32'd0);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            #3;
            chk($sformatf("wd_wait%0d_state", k), 32'(b_st), 32'd1);
            chk($sformatf("wd_wait%0d_timeout", k), 32'(b_to), 32'd0);
            next_cycle();
        end
        #3;
        chk("wd_halt_state", 32'(b_st), 32'd3);
        chk("wd_halt_timeout", 32'(b_to), 32'd1);
        chk("wd_halt_out", 32'(b_out), 32'(O_OFF));
        chk("wd_halt_cnt", 32'(b_cnt), 32'd5);
        set_in(6'b001100);
        repeat (4) next_cycle();
        #3;
        chk("wd_stuck_state", 32'(b_st), 32'd3);
        chk("wd_stuck_timeout", 32'(b_to), 32'd1);
        chk("wd_sat_cnt", 32'(b_cnt), 32'd7);
        rst_b_n = 1'b0;
        #1;
        chk("wd_rst_state", 32'(b_st), 32'd0);
        chk("wd_rst_cnt", 32'(b_cnt), 32'd0);
        chk("wd_rst_timeout", 32'(b_to), 32'd0);
        chk("wd_rst_out", 32'(b_out), 32'(O_OFF));
        next_cycle();
        rst_b_n = 1'b1;
        set_in(6'b000000);
        #3;
        chk("wd_after_out", 32'(b_out), 32'(O_DEF));
        chk("wd_after_state", 32'(b_st), 32'd0);
        next_cycle();
        #3;
        chk("wd_after_cnt", 32'(b_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
